// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Pipeline hazard unit with a multicycle (MUL/DIV) execute sequencer.
//   Resolves RAW hazards either by bypass forwarding (FWD_EN=1) or by
//   stalling (FWD_EN=0). It also detects load-use hazards and control
//   redirects, holds the front end while a multicycle op occupies E, and
//   counts stalled fetch cycles in a saturating counter.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rs1d, rs2d               decode-stage source registers
//   rs1e, rs2e, rde          execute-stage sources / destination
//   rdm, rdw                 memory / writeback destinations
//   regwritee/m/w            destination write enables per stage
//   resultsrce               execute result source (2'b01 = load)
//   pcsrce                   execute PC select (nonzero = redirect)
//   mc_start_e               multicycle op enters E (single-cycle pulse)
//   stallf, stalld, stalle   hold F / D / E pipeline registers
//   flushd, flushe           clear D / E pipeline registers
//   fwae, fwbe               operand bypass select (10 M, 01 W, 00 RF)
//   mc_busy, mc_done         multicycle unit busy / result ready
//   stall_cnt                saturating count of cycles with stallf high
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1d,
    input  logic [REG_AW-1:0] rs2d,
    input  logic [REG_AW-1:0] rs1e,
    input  logic [REG_AW-1:0] rs2e,
    input  logic [REG_AW-1:0] rde,
    input  logic [REG_AW-1:0] rdm,
    input  logic [REG_AW-1:0] rdw,
    input  logic              regwritee,
    input  logic              regwritem,
    input  logic              regwritew,
    input  logic [1:0]        resultsrce,
    input  logic [1:0]        pcsrce,
    input  logic              mc_start_e,
    output logic              stallf,
    output logic              stalld,
    output logic              stalle,
    output logic              flushd,
    output logic              flushe,
    output logic [1:0]        fwae,
    output logic [1:0]        fwbe,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CW = $clog2(MC_LAT);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(MC_LAT - 2);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] SC_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // ------------------------------------------------------------------
    // Combinational hazard detection (x0 never creates a hazard)
    // ------------------------------------------------------------------
    logic ld_hz, rs1_raw, rs2_raw, raw_hz, hz_stall, redirect, busy;

    assign ld_hz = (resultsrce == 2'b01) && (rde != '0) &&
                   ((rde == rs1d) || (rde == rs2d));

    assign rs1_raw = (rs1d != '0) &&
                     ((regwritee && (rs1d == rde)) || (regwritem && (rs1d == rdm)));
    assign rs2_raw = (rs2d != '0) &&
                     ((regwritee && (rs2d == rde)) || (regwritem && (rs2d == rdm)));
    assign raw_hz  = (FWD_EN == 0) && (rs1_raw || rs2_raw);

    assign hz_stall = ld_hz || raw_hz;
    assign redirect = (pcsrce != 2'b00);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. The counter holds the BUSY cycles still to run
    // including the current one; leaving BUSY when the decremented value
    // reaches zero yields exactly MC_LAT-2 BUSY cycles. With MC_LAT=2 no
    // BUSY cycle exists, so the start cycle goes straight to DONE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (mc_start_e) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (MC_LAT == 2) ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = (cnt_q != '0) ? (cnt_q - CNT_ONE) : '0;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. While BUSY the op is held in E, so bubbles and redirect
    // flushes are suppressed. All hazard controls are forced low in reset.
    // ------------------------------------------------------------------
    assign busy    = (state_q == BUSY);
    assign mc_busy = busy;
    assign mc_done = (state_q == DONE);

    always_comb begin
        stallf = 1'b0;
        stalld = 1'b0;
        stalle = 1'b0;
        flushd = 1'b0;
        flushe = 1'b0;
        fwae   = 2'b00;
        fwbe   = 2'b00;
        if (!rst) begin
            stallf = hz_stall || busy;
            stalld = hz_stall || busy;
            stalle = busy;
            // D register gives flushd priority over stalld.
            flushd = !busy && redirect;
            flushe = !busy && (hz_stall || redirect);
            if (FWD_EN != 0) begin
                if (regwritem && (rdm != '0) && (rdm == rs1e)) begin
                    fwae = 2'b10;
                end else if (regwritew && (rdw != '0) && (rdw == rs1e)) begin
                    fwae = 2'b01;
                end
                if (regwritem && (rdm != '0) && (rdm == rs2e)) begin
                    fwbe = 2'b10;
                end else if (regwritew && (rdw != '0) && (rdw == rs2e)) begin
                    fwbe = 2'b01;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall performance counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stallf && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + SC_ONE;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
